neuron_layer_sequencer: RTL and testbench
=========================================

# neuron_layer_sequencer

Sequencer that computes one fully connected neuron layer over the shared 128x8 neuron dual-port RAM. On `start` it reads inputs, weights and biases from the RAM and runs a signed multiply-accumulate per neuron. It applies a ReLU-shift-saturate activation and writes each result back into the same RAM. While idle it hands the RAM ports to a host requester, so the RAM can be loaded and read back between layer runs.

## Interface
- `N_INPUTS`, default 8: inputs per neuron, 1..16.
- `N_NEURONS`, default 4: neurons in the layer, 1..8.
- `INPUT_BASE`, default 0: RAM address of input[0].
- `WEIGHT_BASE`, default 8: RAM address of weight[0][0]. weight[j][i] is at `WEIGHT_BASE + j*N_INPUTS + i`.
- `BIAS_BASE`, default 40: RAM address of bias[0]. bias[j] is at `BIAS_BASE + j`.
- `OUT_BASE`, default 44: RAM address of out[0]. out[j] is at `OUT_BASE + j`.
- `SHIFT`, default 4: arithmetic right shift applied before saturation.
- Every address region must lie within 0..127. The output region must not overlap the input, weight or bias regions.
- `clk`  in  1  the single clock. All state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle request to run the layer. Sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through the WRITE of the last neuron.
- `done`  out  1  one-cycle pulse after the last write.
- `host_req`  in  1  host requests a RAM access.
- `host_we`  in  1  host access is a write.
- `host_addr`  in  8  host RAM address.
- `host_wdata`  in  8  host write data.
- `host_gnt`  out  1  host access is performed this cycle.
- `host_rdata`  out  8  equals `ram_read_data`; valid when `host_gnt && !host_we`.
- `ram_read_address`  out  8  to the RAM read port.
- `ram_write_address`  out  8  to the RAM write port.
- `ram_write_data`  out  8  to the RAM write port.
- `ram_oe`  out  1  RAM read enable.
- `ram_wre`  out  1  RAM write enable.
- `ram_read_data`  in  8  from the RAM. Combinational read, valid in the same cycle as the address.

## Operation
- States: IDLE, BIAS, RD_IN, MAC, ACT, WRITE, DONE. Counters: neuron index `j` and input index `i`.
- IDLE:
  - `start` sets `j=0`, `i=0` and goes to BIAS.
  - If `start` is low, `host_gnt = host_req`, and the RAM ports are driven from the host signals.
  - When `start` and `host_req` coincide, `start` wins and `host_gnt` stays 0.
- BIAS: read `BIAS_BASE+j`. Load acc with the sign-extended bias. Go to RD_IN.
- RD_IN: read `INPUT_BASE+i`. Latch it into the 8-bit `x` register. Go to MAC.
- MAC: read `WEIGHT_BASE+j*N_INPUTS+i` and do `acc += x*weight`.
  - If `i==N_INPUTS-1`, set `i=0` and go to ACT.
  - Otherwise set `i++` and go to RD_IN.
- ACT: register `res`.
  - If acc<0, `res=0`.
  - Otherwise take `acc>>>SHIFT`; if that exceeds 127, `res=127`.
- WRITE: `ram_wre=1`, write address `OUT_BASE+j`, data `res`.
  - If `j==N_NEURONS-1`, go to DONE.
  - Otherwise set `j++` and go to BIAS.
- DONE: `done=1` for one cycle, then go to IDLE.
- Arithmetic:
  - All RAM data is signed two's complement.
  - The product is signed 16-bit.
  - acc is signed 21-bit, which cannot overflow within the parameter limits.
  - Address arithmetic is 8-bit.
- `ram_oe` is 1 only in BIAS, RD_IN, MAC and granted host reads. Otherwise it is 0, and the RAM drives Z.
- `ram_wre` is 1 only in WRITE and granted host writes. It is gated with `rst_n`, so no write occurs in a cycle where reset is asserted.
- Reset: state IDLE, `j=i=0`, `acc=0`, `x=0`, `res=0`. All outputs 0, including the address and data outputs.
- Reset mid-run aborts the run. Outputs already written stay in the RAM, and no `done` is issued.
- `start` during busy is ignored. `host_req` during busy is stalled with `host_gnt=0`; the host must hold its request.

## Timing
- `start` is sampled high at edge k. BIAS runs in cycle k+1, and `busy` is high from cycle k+1.
- Cycles per neuron: 2*N_INPUTS+3. With defaults that is 19 cycles per neuron and 76 cycles in total.
- The WRITE of the last neuron is in cycle k+76, and `done` is high in cycle k+77.
- `busy` is low in DONE and in IDLE.
- Host access: grant, read data and write all happen in the same cycle, with zero wait states when idle.
- The sequencer never reads and writes the same address in one cycle. The RAM's write-forwarding is therefore not relied upon.

## Test plan
- Defaults with inputs=1, neuron0 weights=2, bias0=0 → out[0]=mem[44]=1 (acc 16>>4). Check `done` exactly 77 cycles after `start`.
- Neuron1 weights=16, inputs=1, bias1=5 → acc 133, mem[45]=8. Neuron2 weights=0xFF (-1), bias 0 → acc -8, mem[46]=0.
- Neuron3 inputs=127, weights=127 → acc 129032, mem[47]=127 (saturated). Also check inputs=-128 and weights=-128 → 127.
- Host writes and reads back mem[5]=0xA5 while idle with `host_gnt` high each cycle. Assert `host_req` during a run → `host_gnt` stays 0 until DONE, then the access completes.
- `start` and `host_req` in the same IDLE cycle → run begins and `host_gnt`=0. A second `start` mid-run → ignored, total still 76 cycles.
- Deassert `rst_n` during the third neuron's WRITE → mem[46] unchanged, and `busy`, `done`, `ram_wre` are all 0 next cycle. A fresh `start` then produces correct outputs.

Source files
------------

// File: rtl/neuron_layer_sequencer.sv
// rtl/neuron_layer_sequencer.sv - fully connected neuron layer sequencer over a shared 128x8 RAM
// Host owns the RAM ports while idle; a started run streams bias, input/weight MACs, activation, write-back.
module neuron_layer_sequencer #(
  parameter int N_INPUTS    = 8,
  parameter int N_NEURONS   = 4,
  parameter int INPUT_BASE  = 0,
  parameter int WEIGHT_BASE = 8,
  parameter int BIAS_BASE   = 40,
  parameter int OUT_BASE    = 44,
  parameter int SHIFT       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic [7:0] host_rdata,
  output logic [7:0] ram_read_address,
  output logic [7:0] ram_write_address,
  output logic [7:0] ram_write_data,
  output logic       ram_oe,
  output logic       ram_wre,
  input  logic [7:0] ram_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_RD_IN, S_MAC, S_ACT, S_WRITE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         j;
  logic [4:0]         i;
  logic signed [20:0] acc;
  logic [7:0]         x;
  logic [7:0]         res;

  logic               last_i, last_j;
  logic signed [15:0] prod;
  logic signed [20:0] shifted;
  logic [7:0]         act_val;
  logic [7:0]         bias_addr, in_addr, weight_addr, out_addr;

  assign last_i      = (i == 5'(N_INPUTS - 1));
  assign last_j      = (j == 4'(N_NEURONS - 1));
  assign prod        = $signed(x) * $signed(ram_read_data);
  assign shifted     = acc >>> SHIFT;
  assign bias_addr   = 8'(BIAS_BASE + int'(j));
  assign in_addr     = 8'(INPUT_BASE + int'(i));
  assign weight_addr = 8'(WEIGHT_BASE + int'(j) * N_INPUTS + int'(i));
  assign out_addr    = 8'(OUT_BASE + int'(j));
  assign host_rdata  = ram_read_data;

  // ReLU, then arithmetic shift, then clamp to the positive 8-bit range
  always_comb begin
    act_val = shifted[7:0];
    if (acc[20])
      act_val = 8'd0;
    else if (shifted > 21'sd127)
      act_val = 8'd127;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      j     <= '0;
      i     <= '0;
      acc   <= '0;
      x     <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:  if (start) begin j <= '0; i <= '0; end
        S_BIAS:  acc <= {{13{ram_read_data[7]}}, ram_read_data};
        S_RD_IN: x <= ram_read_data;
        S_MAC: begin
          acc <= acc + {{5{prod[15]}}, prod};
          i   <= last_i ? 5'd0 : i + 5'd1;
        end
        S_ACT:   res <= act_val;
        S_WRITE: if (!last_j) j <= j + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt         = state;
    busy              = 1'b0;
    done              = 1'b0;
    host_gnt          = 1'b0;
    ram_oe            = 1'b0;
    ram_wre           = 1'b0;
    ram_read_address  = 8'd0;
    ram_write_address = 8'd0;
    ram_write_data    = 8'd0;

    case (state)
      S_IDLE:  if (start) state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_RD_IN;
      S_RD_IN: state_nxt = S_MAC;
      S_MAC:   state_nxt = last_i ? S_ACT : S_RD_IN;
      S_ACT:   state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_j ? S_DONE : S_BIAS;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Output drive is suppressed entirely while reset is held, so no stray write can land
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (!start) begin
            host_gnt          = host_req;
            ram_oe            = host_req & ~host_we;
            ram_wre           = host_req & host_we;
            ram_read_address  = host_addr;
            ram_write_address = host_addr;
            ram_write_data    = host_wdata;
          end
        end
        S_BIAS: begin
          busy             = 1'b1;
          ram_oe           = 1'b1;
          ram_read_address = bias_addr;
        end
        S_RD_IN: begin
          busy             = 1'b1;
          ram_oe           = 1'b1;
          ram_read_address = in_addr;
        end
        S_MAC: begin
          busy             = 1'b1;
          ram_oe           = 1'b1;
          ram_read_address = weight_addr;
        end
        S_ACT:   busy = 1'b1;
        S_WRITE: begin
          busy              = 1'b1;
          ram_wre           = 1'b1;
          ram_write_address = out_addr;
          ram_write_data    = res;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb/tb_neuron_layer_sequencer.sv - self-checking bench for neuron_layer_sequencer with a RAM model
module tb_neuron_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'd0;
  logic [7:0] host_wdata = 8'd0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic [7:0] ram_read_address, ram_write_address, ram_write_data;
  logic       ram_oe, ram_wre;
  logic [7:0] ram_read_data;

  logic [7:0] mem [256];
  logic signed [7:0] sh [128];

  int total = 0;
  int passed = 0;

  typedef struct {
    int x;
    int w;
    int b;
    int exp;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  neuron_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data), .ram_oe(ram_oe), .ram_wre(ram_wre),
    .ram_read_data(ram_read_data)
  );

  assign ram_read_data = ram_oe ? mem[ram_read_address] : 8'h00;

  always @(posedge clk) begin
    if (ram_wre) mem[ram_write_address] <= ram_write_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: dot product plus bias, ReLU, divide by 16 (floor), clamp to 127
  function automatic int model_out(int n);
    int acc;
    acc = int'(sh[40 + n]);
    for (int k = 0; k < 8; k++) acc += int'(sh[k]) * int'(sh[8 + n * 8 + k]);
    if (acc < 0) return 0;
    acc = acc >>> 4;
    return (acc > 127) ? 127 : acc;
  endfunction

  task automatic host_write(input int a, input logic [7:0] d, output bit g);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'(a); host_wdata = d;
    #1 g = host_gnt;
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input int a, output int d, output bit g);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'(a);
    #1 g = host_gnt; d = int'(host_rdata);
    host_req = 1'b0;
  endtask

  task automatic load_layer();
    bit g;
    for (int a = 0; a < 44; a++) host_write(a, sh[a], g);
  endtask

  task automatic fill_uniform(input int xv, input int wv, input int bv);
    for (int a = 0; a < 8; a++) sh[a] = 8'(xv);
    for (int a = 8; a < 40; a++) sh[a] = 8'(wv);
    for (int a = 40; a < 44; a++) sh[a] = 8'(bv);
  endtask

  // Pulses start, returns cycles from the accepting edge to the cycle where done is seen
  task automatic run_layer(input int mid_start, output int lat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == mid_start);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, d, n;
    bit g, early;
    int exp4 [4];

    tbl[0] = '{1, 2, 0, 1};
    tbl[1] = '{1, 16, 5, 8};
    tbl[2] = '{1, -1, 0, 0};
    tbl[3] = '{127, 127, 0, 127};
    tbl[4] = '{-128, -128, 0, 127};
    tbl[5] = '{3, -2, 100, 3};
    tbl[6] = '{-5, 7, -128, 0};

    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd9; host_wdata = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_gnt", int'(host_gnt), 0);
    chk("rst_wre", int'(ram_wre), 0);
    chk("rst_oe", int'(ram_oe), 0);
    chk("rst_waddr", int'(ram_write_address), 0);
    chk("rst_raddr", int'(ram_read_address), 0);
    host_req = 1'b0; host_we = 1'b0;
    rst_n = 1'b1;

    host_write(5, 8'hA5, g);
    chk("host_wr_gnt", int'(g), 1);
    host_read(5, d, g);
    chk("host_rd_gnt", int'(g), 1);
    chk("host_rd_data", d, 'hA5);

    // start and host_req together: start wins, then a second start mid-run is ignored
    @(posedge clk); #1;
    start = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 8'h11;
    #1;
    chk("coinc_gnt", int'(host_gnt), 0);
    chk("coinc_wre", int'(ram_wre), 0);
    @(posedge clk); #1;
    start = 1'b0; host_req = 1'b0; host_we = 1'b0;
    chk("busy_first_cycle", int'(busy), 1);
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 20);
    end
    start = 1'b0;
    chk("mid_start_latency", lat, 77);
    host_read(5, d, g);
    chk("coinc_no_write", d, 'hA5);

    // per-neuron pattern: out = {1, 8, 0, 2}
    fill_uniform(1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      sh[8 + k] = 8'sd2; sh[16 + k] = 8'sd16; sh[24 + k] = -8'sd1; sh[32 + k] = 8'sd5;
    end
    sh[41] = 8'sd5; sh[43] = -8'sd3;
    load_layer();
    run_layer(0, lat);
    chk("pattern_latency", lat, 77);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    exp4 = '{1, 8, 0, 2};
    for (int k = 0; k < 4; k++) begin
      host_read(44 + k, d, g);
      chk($sformatf("pattern_out%0d", k), d, exp4[k]);
    end

    // host stalled during a run, granted only once back in IDLE
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd44;
    #1;
    n = 1; early = 1'b0;
    while (!host_gnt && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    early = busy | done;
    d = int'(host_rdata);
    host_req = 1'b0;
    chk("stall_gnt_cycle", n, 78);
    chk("stall_gnt_idle", int'(early), 0);
    chk("stall_rdata", d, 1);

    for (int t = 0; t < 7; t++) begin
      fill_uniform(tbl[t].x, tbl[t].w, tbl[t].b);
      load_layer();
      run_layer(0, lat);
      chk($sformatf("tbl%0d_latency", t), lat, 77);
      for (int k = 0; k < 4; k++) begin
        host_read(44 + k, d, g);
        chk($sformatf("tbl%0d_out%0d", t, k), d, tbl[t].exp);
      end
    end

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 44; a++) sh[a] = 8'($urandom_range(0, 255));
      if (r == 0) for (int a = 0; a < 40; a++) sh[a] = 8'sd127;
      load_layer();
      run_layer(0, lat);
      for (int k = 0; k < 4; k++) begin
        host_read(44 + k, d, g);
        chk($sformatf("rand%0d_out%0d", r, k), d, model_out(k));
      end
    end

    // reset during the third neuron's write
    fill_uniform(1, 16, 5);
    load_layer();
    host_write(46, 8'h5A, g);
    run_layer(57, lat);
    host_write(46, 8'h5A, g);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    chk("abort_wre_before", int'(ram_wre), 1);
    chk("abort_waddr_before", int'(ram_write_address), 46);
    rst_n = 1'b0;
    #1;
    chk("abort_wre_gated", int'(ram_wre), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wre", int'(ram_wre), 0);
    host_read(46, d, g);
    chk("abort_mem46_kept", d, 'h5A);
    host_read(45, d, g);
    chk("abort_mem45_written", d, 8);
    run_layer(0, lat);
    chk("rerun_latency", lat, 77);
    for (int k = 0; k < 4; k++) begin
      host_read(44 + k, d, g);
      chk($sformatf("rerun_out%0d", k), d, 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
